// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: requester A/B handshakes, clear, and RAM/valid-LED side of ram_access_ctrl.
interface ram_access_ctrl_if #(
    parameter int ADDRWIDTH = 3,
    parameter int DATAWIDTH = 8
);
    localparam int DEPTH = 1 << ADDRWIDTH;
    logic                 a_req, a_we, a_ack, a_hit;
    logic [ADDRWIDTH-1:0] a_addr;
    logic [DATAWIDTH-1:0] a_wdata, a_rdata;
    logic                 b_req, b_we, b_ack, b_hit;
    logic [ADDRWIDTH-1:0] b_addr;
    logic [DATAWIDTH-1:0] b_wdata, b_rdata;
    logic                 clr;
    logic                 mem_wr;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [DATAWIDTH-1:0] mem_wdata, mem_rdata;
    logic                 valid;
    logic [DEPTH-1:0]     v_led;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, clr, mem_rdata,
        input  a_ack, a_rdata, a_hit, b_ack, b_rdata, b_hit, mem_wr, mem_addr, mem_wdata, valid, v_led
    );
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, clr, mem_rdata,
        output a_ack, a_rdata, a_hit, b_ack, b_rdata, b_hit, mem_wr, mem_addr, mem_wdata, valid, v_led
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: arbitrates requesters A/B onto one RAM port and keeps a valid bit per word.
// Define RR_ARB_EN for round-robin arbitration; otherwise A has fixed priority.
module ram_access_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int DATAWIDTH = 8
) (
    input logic             clk_i,
    input logic             reset_ni,
    ram_access_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDRWIDTH;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t               state_q, state_d;
    logic [DEPTH-1:0]     valid_q;
    logic                 clr_pend_q, we_q, win_b_q, grant, do_clr, pick_b;
    logic                 a_ack_q, b_ack_q, a_hit_q, b_hit_q, mem_wr_q;
    logic [ADDRWIDTH-1:0] mem_addr_q;
    logic [DATAWIDTH-1:0] mem_wdata_q;

`ifdef RR_ARB_EN
    logic last_b_q;
    assign pick_b = bus.b_req & (~bus.a_req | ~last_b_q);
    always_ff @(posedge clk_i) begin
        if (!reset_ni) last_b_q <= 1'b1;
        else if (grant) last_b_q <= pick_b;
    end
`else
    assign pick_b = bus.b_req & ~bus.a_req;
`endif

    always_comb begin
        state_d = state_q;
        do_clr  = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                do_clr  = bus.clr | clr_pend_q;
                grant   = ~do_clr & (bus.a_req | bus.b_req);
                state_d = grant ? ACCESS : IDLE;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q     <= '0;
            clr_pend_q  <= 1'b0;
            we_q        <= 1'b0;
            win_b_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_hit_q     <= 1'b0;
            b_hit_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_hit_q    <= 1'b0;
            b_hit_q    <= 1'b0;
            mem_wr_q   <= 1'b0;
            clr_pend_q <= ~do_clr & (clr_pend_q | bus.clr);
            if (do_clr) valid_q <= '0;
            if (grant) begin
                win_b_q     <= pick_b;
                we_q        <= pick_b ? bus.b_we : bus.a_we;
                mem_wr_q    <= pick_b ? bus.b_we : bus.a_we;
                mem_addr_q  <= pick_b ? bus.b_addr : bus.a_addr;
                mem_wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
            end
            // Hit is taken from the valid bit before this cycle's write lands.
            if (state_q == ACCESS) begin
                if (we_q) valid_q[mem_addr_q] <= 1'b1;
                a_ack_q <= ~win_b_q;
                b_ack_q <= win_b_q;
                a_hit_q <= ~win_b_q & (we_q | valid_q[mem_addr_q]);
                b_hit_q <= win_b_q & (we_q | valid_q[mem_addr_q]);
            end
        end
    end

    // RAM data arrives one cycle after ACCESS, so read data is gated straight through in RESP.
    assign bus.a_rdata   = (a_ack_q & a_hit_q & ~we_q) ? bus.mem_rdata : '0;
    assign bus.b_rdata   = (b_ack_q & b_hit_q & ~we_q) ? bus.mem_rdata : '0;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_hit     = a_hit_q;
    assign bus.b_hit     = b_hit_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.valid     = valid_q[mem_addr_q];
    assign bus.v_led     = valid_q;
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Controller that sequences all accesses to the lab RAM and its per-word valid-bit array, sharing the single RAM port between two requesters (A, B). Each requester issues a read or write with a REQ/ACK handshake. The block arbitrates between them, drives the RAM control lines, maintains one valid bit per word, and returns read data with a hit flag. It sits between the front-panel or test requesters and the RAM/valid-LED datapath.

## Interface
Parameters:
- ADDRWIDTH, 3, address width; DEPTH = 1<<ADDRWIDTH words
- DATAWIDTH, 8, RAM word width

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RESET  in  1  synchronous, active-low reset
- A_REQ / B_REQ  in  1  request; held high with fields stable until the matching ACK
- A_WE / B_WE  in  1  1 = write, 0 = read
- A_ADDR / B_ADDR  in  ADDRWIDTH  word address
- A_WDATA / B_WDATA  in  DATAWIDTH  write data
- A_ACK / B_ACK  out  1  one-cycle completion pulse
- A_RDATA / B_RDATA  out  DATAWIDTH  read data, valid while ACK=1
- A_HIT / B_HIT  out  1  addressed word was valid, qualified by ACK
- CLR  in  1  invalidate all words (one-cycle pulse or level)
- MEM_WR  out  1  RAM write strobe
- MEM_ADDR  out  ADDRWIDTH  RAM address
- MEM_WDATA  out  DATAWIDTH  RAM write data
- MEM_RDATA  in  DATAWIDTH  RAM read data, registered, 1-cycle latency from MEM_ADDR
- VALID  out  1  valid bit of current MEM_ADDR
- V_LED  out  DEPTH  all valid bits, bit i = word i

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: a pending CLR has priority. It clears all valid bits this cycle and grants nothing. Otherwise, if any REQ=1, the arbiter picks a winner, latches its WE/ADDR/WDATA, and moves to ACCESS.
- ACCESS (1 cycle): MEM_ADDR = latched addr.
  - Write: MEM_WR=1, MEM_WDATA = latched data, valid[addr] set at the end of the cycle.
  - Read: MEM_WR=0; the hit flag is captured from valid[addr].
  - Go to RESP.
- RESP (1 cycle): winner's ACK=1.
  - Read: RDATA = MEM_RDATA if hit, else 0; HIT = captured flag.
  - Write: RDATA=0, HIT=1.
  - Go to IDLE.
- Loser's REQ stays pending and is serviced in a later grant. No request is dropped.
- REQ still high in the IDLE cycle after ACK counts as a new request.
- CLR asserted outside IDLE is latched as pending and applied at the next IDLE, before any grant. The in-flight access completes normally.
- A write to an already-valid word overwrites the data; its valid bit stays 1.
- A_ADDR and B_ADDR may be equal. Accesses are serialized, so the later access observes the earlier one's effect.
- Reset (RESET=0 at a clock edge) in any state:
  - FSM → IDLE, no ACK issued.
  - All valid bits = 0, pending CLR cleared, arbiter pointer reset.
  - Takes effect immediately, including mid-ACCESS.

## Timing
- Reset values: A_ACK=B_ACK=0, A/B_RDATA=0, A/B_HIT=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0, V_LED=0, VALID=0, FSM=IDLE.
- Latency: REQ sampled high in IDLE at edge n → ACCESS during cycle n+1 → ACK high during cycle n+2 → IDLE at n+3.
- Throughput: at most one access per 3 cycles. Back-to-back grants alternate per the arbiter.
- CLR is applied in 1 cycle when sampled in IDLE. V_LED shows all zeros on the following cycle.
- MEM_WR is high only in ACCESS, for exactly one cycle per write.
- Outputs are registered except VALID, which is combinational from valid[MEM_ADDR].

## Configuration
- RR_ARB_EN defined: round-robin arbitration.
  - A last-grant pointer flips to the winner on every grant.
  - On a simultaneous request, the non-last requester wins.
  - The pointer resets to B, so A wins the first tie.
- RR_ARB_EN undefined: fixed priority, A always wins ties.
  - B can starve while A requests continuously.

## Test plan
- Reset, then A writes 0x5A to addr 3 → A_ACK at n+2; MEM_WR pulses once with MEM_ADDR=3; V_LED=8'b0000_1000.
- B reads addr 3 after the write above → B_ACK, B_HIT=1, B_RDATA=0x5A. B reads addr 5 → B_HIT=0, B_RDATA=0.
- A and B request simultaneously and continuously, both reads:
  - With RR_ARB_EN, ACKs alternate A,B,A,B.
  - Without RR_ARB_EN, only A_ACK pulses.
- CLR pulsed during ACCESS of a write to addr 1:
  - The write completes and ACK is issued.
  - The next IDLE clears all bits: V_LED=0. No grant occurs in that cycle.
- RESET low during ACCESS of an A write → no A_ACK; V_LED=0. After reset, A's held REQ is regranted; ACK arrives 2 cycles after the first IDLE sample.
